// File: rtl/z88_bus_pkg.sv
// Shared Z88 bus definitions: bus-master state encoding and Blink IO port map.
package z88_bus_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StT1,
        StT2,
        StTw,
        StT3,
        StDone
    } bus_state_e;

    // Blink IO port numbers (low address byte of an IO cycle)
    localparam logic [7:0] PortCom = 8'hB0;
    localparam logic [7:0] PortInt = 8'hB1;
    localparam logic [7:0] PortTmk = 8'hB5;
    localparam logic [7:0] PortSr0 = 8'hD0;
    localparam logic [7:0] PortSr1 = 8'hD1;
    localparam logic [7:0] PortSr2 = 8'hD2;
    localparam logic [7:0] PortSr3 = 8'hD3;
    localparam logic [7:0] PortPb0 = 8'h70;
    localparam logic [7:0] PortPb1 = 8'h71;
    localparam logic [7:0] PortPb2 = 8'h72;
    localparam logic [7:0] PortPb3 = 8'h73;
    localparam logic [7:0] PortSbr = 8'h74;

endpackage

// File: rtl/z80_tstate_timer.sv
// T-state divider: counts mck cycles 0..TS_DIV-1 while running, flags the last one.
module z80_tstate_timer #(
    parameter int unsigned TS_DIV = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic last
);

    localparam logic [3:0] CntLast = 4'(TS_DIV - 1);

    logic [3:0] cnt_q, cnt_d;

    assign last = run && (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q;
        if (!run || last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/z80_bus_master.sv
// Host-driven Z80 bus initiator: turns single mem/IO requests into T-state-timed
// cycles on the Blink bus pins while the CPU clock is stopped.
module z80_bus_master
    import z88_bus_pkg::*;
#(
    parameter int unsigned TS_DIV  = 3,
    parameter int unsigned IO_WAIT = 1
) (
    input  logic        mck,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_io,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [15:0] ca,
    output logic [7:0]  bd_o,
    output logic        bd_oe,
    input  logic [7:0]  bd_i,
    output logic        mrq_n,
    output logic        ior_n,
    output logic        crd_n,
    output logic        cm1_n,
    output logic        hlt_n
);

    localparam logic [1:0] WaitLast = 2'((IO_WAIT == 0) ? 0 : IO_WAIT - 1);

    bus_state_e  state_q, state_d;
    logic [1:0]  wait_q, wait_d;
    logic        io_q, wr_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q, rdata_q;
    logic        accept, ts_run, ts_last, strobe;

    assign accept = req_valid && req_ready;
    assign ts_run = state_q inside {StT1, StT2, StTw, StT3};
    assign strobe = state_q inside {StT2, StTw, StT3};

    z80_tstate_timer #(
        .TS_DIV (TS_DIV)
    ) u_timer (
        .clk  (mck),
        .rst  (rst),
        .run  (ts_run),
        .last (ts_last)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StT1;
            StT1:   if (ts_last) state_d = StT2;
            StT2: begin
                if (ts_last) begin
                    if (io_q && (IO_WAIT != 0)) begin
                        state_d = StTw;
                        wait_d  = '0;
                    end else begin
                        state_d = StT3;
                    end
                end
            end
            StTw: begin
                if (ts_last) begin
                    if (wait_q == WaitLast) begin
                        state_d = StT3;
                    end else begin
                        wait_d = wait_q + 2'd1;
                    end
                end
            end
            StT3:   if (ts_last) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge mck or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            wait_q  <= '0;
            io_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (accept) begin
                io_q    <= req_io;
                wr_q    <= req_wr;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if ((state_q == StT3) && ts_last && !wr_q) begin
                rdata_q <= bd_i;
            end
        end
    end

    // Strobes decode from registered state only, so crd_n and the request strobe
    // change on the same edge and drop together on async reset.
    assign mrq_n     = !(strobe && !io_q);
    assign ior_n     = !(strobe && io_q);
    assign crd_n     = !(strobe && !wr_q);
    assign bd_oe     = ts_run && wr_q;
    assign bd_o      = wdata_q;
    assign ca        = addr_q;
    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StDone);
    assign rsp_rdata = rdata_q;
    assign cm1_n     = 1'b1;
    assign hlt_n     = 1'b1;

endmodule
